// File: rtl/ifetch_queue_pkg.sv
// pkg_tpu: shared scalar-unit types for the fetch path.
// Rev 1.0
`default_nettype none

package pkg_tpu;

   localparam int unsigned INSTR_W = 32;

   typedef logic [INSTR_W-1:0] instr_t;

   typedef enum logic [1:0] {
      IFQ_IDLE  = 2'd0,
      IFQ_RUN   = 2'd1,
      IFQ_DRAIN = 2'd2
   } ifq_state_t;

endpackage : pkg_tpu

`default_nettype wire

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: buffer-read, decode handshake and control bundle of the fetch stage.
// Rev 1.0
`default_nettype none

interface ifetch_queue_if;
   import pkg_tpu::*;

   logic   I_Req;
   logic   I_Empty;
   logic   I_Term;
   logic   I_Flush;
   logic   I_Stall;
   instr_t I_Instr;
   logic   O_Re_Buff;
   logic   O_Req;
   instr_t O_Instr;
   logic   O_Busy;
   logic   O_Done;

   modport slave (
      input  I_Req, I_Empty, I_Term, I_Flush, I_Stall, I_Instr,
      output O_Re_Buff, O_Req, O_Instr, O_Busy, O_Done
   );

   modport master (
      output I_Req, I_Empty, I_Term, I_Flush, I_Stall, I_Instr,
      input  O_Re_Buff, O_Req, O_Instr, O_Busy, O_Done
   );

endinterface : ifetch_queue_if

`default_nettype wire

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry instr_t prefetch FIFO with occupancy and head output.
// Rev 1.0
`default_nettype none

module ifq_fifo
   import pkg_tpu::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic             i_clr,
   input  wire logic             i_push,
   input  wire instr_t           i_data,
   input  wire logic             i_pop,
   output logic      [CNT_W-1:0] o_occ,
   output instr_t                o_head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   instr_t            r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_occ;
   logic              w_pop;

   assign w_pop = i_pop & (r_occ != '0);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         // Push and pop together leave the count untouched.
         if (i_push && !w_pop) begin
            r_occ <= r_occ + CNT_W'(1);
         end else if (!i_push && w_pop) begin
            r_occ <= r_occ - CNT_W'(1);
         end
      end
   end

   assign o_occ  = r_occ;
   assign o_head = r_mem[r_rd_ptr];

endmodule : ifq_fifo

`default_nettype wire

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch FSM, read-credit logic and in-flight tracking around ifq_fifo.
// Rev 1.0
`default_nettype none

module ifetch_queue
   import pkg_tpu::*;
#(
   parameter int DEPTH  = 4,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input wire logic       clock,
   input wire logic       reset,
   ifetch_queue_if.slave  bus
);

   localparam int SUM_W = $clog2(DEPTH + RD_LAT + 1);
   localparam logic [SUM_W-1:0] c_depth_lim = SUM_W'(DEPTH);

   ifq_state_t        r_state;
   ifq_state_t        w_state_nxt;
   logic [RD_LAT-1:0] r_vld;
   logic [CNT_W-1:0]  w_occ;
   logic [SUM_W-1:0]  w_inflight;
   logic [SUM_W-1:0]  w_credit;
   logic              w_drained;
   logic              w_re;
   logic              w_done;
   logic              w_busy;
   logic              w_push;
   logic              w_req;
   logic              w_pop;
   instr_t            w_head;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         w_inflight = w_inflight + SUM_W'(r_vld[i]);
      end
   end

   // Credits count the queue plus every read still travelling; a pop this cycle frees nothing.
   assign w_credit  = SUM_W'(w_occ) + w_inflight;
   assign w_drained = (w_occ == '0) && (r_vld == '0);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= IFQ_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.I_Flush) begin
         w_state_nxt = IFQ_IDLE;
      end else begin
         unique case (r_state)
            IFQ_IDLE:  if (bus.I_Req && !bus.I_Term) w_state_nxt = IFQ_RUN;
            IFQ_RUN:   if (bus.I_Term)               w_state_nxt = IFQ_DRAIN;
            IFQ_DRAIN: if (w_drained)                w_state_nxt = IFQ_IDLE;
            default:                                 w_state_nxt = IFQ_IDLE;
         endcase
      end
   end

   always_comb begin
      w_re   = 1'b0;
      w_done = 1'b0;
      w_busy = (r_state != IFQ_IDLE);
      if (r_state == IFQ_RUN) begin
         w_re = !bus.I_Empty && !bus.I_Term && !bus.I_Flush && (w_credit < c_depth_lim);
      end
      if (r_state == IFQ_DRAIN) begin
         w_done = w_drained && !bus.I_Flush;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset || bus.I_Flush) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= w_re;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   assign w_push = r_vld[RD_LAT-1];
   assign w_req  = (w_occ != '0);
   assign w_pop  = w_req && !bus.I_Stall;

   ifq_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .i_clr  (bus.I_Flush),
      .i_push (w_push),
      .i_data (bus.I_Instr),
      .i_pop  (w_pop),
      .o_occ  (w_occ),
      .o_head (w_head)
   );

   assign bus.O_Re_Buff = w_re;
   assign bus.O_Req     = w_req;
   assign bus.O_Instr   = w_head;
   assign bus.O_Busy    = w_busy;
   assign bus.O_Done    = w_done;

endmodule : ifetch_queue

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bench; instance a uses RD_LAT=1, instance b uses RD_LAT=2.
// Rev 1.0
`default_nettype none

module tb_ifetch_queue;
   import pkg_tpu::*;

   logic clock;
   logic reset;

   ifetch_queue_if ifa ();
   ifetch_queue_if ifb ();

   ifetch_queue #(.DEPTH(4), .RD_LAT(1)) u_a (.clock(clock), .reset(reset), .bus(ifa));
   ifetch_queue #(.DEPTH(4), .RD_LAT(2)) u_b (.clock(clock), .reset(reset), .bus(ifb));

   int n_checks = 0;
   int n_fail   = 0;
   int exp_a    = 0;
   int exp_b    = 0;
   int npop_a   = 0;
   int pop_mark = 0;
   int ia       = 0;
   int ib       = 0;
   instr_t a_instr = '0;
   instr_t b_d1    = '0;
   instr_t b_instr = '0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic instr_t instr_of(input int k);
      return instr_t'((k + 1) * 17);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Instruction buffer models: data appears RD_LAT cycles after a sampled read-enable.
   always @(posedge clock) begin
      if (ifa.O_Re_Buff) begin
         a_instr <= instr_of(ia);
         ia      <= ia + 1;
      end
      if (ifb.O_Re_Buff) begin
         b_d1 <= instr_of(ib);
         ib   <= ib + 1;
      end
      b_instr <= b_d1;
   end
   assign ifa.I_Instr = a_instr;
   assign ifb.I_Instr = b_instr;

   always @(negedge clock) begin
      if (reset) begin
         chk("a_occ_le_depth", 32'(int'(u_a.u_fifo.r_occ) <= 4), 32'd1);
         chk("b_occ_le_depth", 32'(int'(u_b.u_fifo.r_occ) <= 4), 32'd1);
         if (ifa.O_Req && !ifa.I_Stall) begin
            chk("a_pop_order", ifa.O_Instr, instr_of(exp_a));
            exp_a++;
            npop_a++;
         end
         if (ifb.O_Req && !ifb.I_Stall) begin
            chk("b_pop_order", ifb.O_Instr, instr_of(exp_b));
            exp_b++;
         end
      end
   end

   initial begin
      reset = 1'b0;
      ifa.I_Req = 1'b0; ifa.I_Empty = 1'b0; ifa.I_Term = 1'b0; ifa.I_Flush = 1'b0; ifa.I_Stall = 1'b0;
      ifb.I_Req = 1'b0; ifb.I_Empty = 1'b0; ifb.I_Term = 1'b0; ifb.I_Flush = 1'b0; ifb.I_Stall = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      #1;
      chk("rst_re",    32'(ifa.O_Re_Buff), 32'd0);
      chk("rst_req",   32'(ifa.O_Req),     32'd0);
      chk("rst_instr", ifa.O_Instr,        32'd0);
      chk("rst_busy",  32'(ifa.O_Busy),    32'd0);
      chk("rst_done",  32'(ifa.O_Done),    32'd0);

      // Basic stream
      ifa.I_Req = 1'b1;
      tick(); ifa.I_Req = 1'b0; #1;
      chk("bs_re_e0",   32'(ifa.O_Re_Buff), 32'd1);
      chk("bs_req_e0",  32'(ifa.O_Req),     32'd0);
      chk("bs_busy_e0", 32'(ifa.O_Busy),    32'd1);
      tick(); #1;
      chk("bs_req_e1",  32'(ifa.O_Req),     32'd0);
      chk("bs_re_e1",   32'(ifa.O_Re_Buff), 32'd1);
      tick(); #1;
      chk("bs_req_e2",   32'(ifa.O_Req),     32'd1);
      chk("bs_instr_e2", ifa.O_Instr,        32'h11);
      chk("bs_re_e2",    32'(ifa.O_Re_Buff), 32'd1);
      tick(); #1;
      chk("bs_instr_e3", ifa.O_Instr, 32'h22);

      // Backpressure: six stalled cycles with 0x33 at the head
      tick(); ifa.I_Stall = 1'b1; #1;
      chk("bp_instr_e4", ifa.O_Instr,        32'h33);
      chk("bp_re_e4",    32'(ifa.O_Re_Buff), 32'd1);
      tick(); #1;
      chk("bp_re_e5",    32'(ifa.O_Re_Buff), 32'd1);
      tick(); #1;
      chk("bp_re_full",  32'(ifa.O_Re_Buff), 32'd0);
      chk("bp_req_full", 32'(ifa.O_Req),     32'd1);
      tick(); tick(); tick(); #1;
      chk("bp_instr_hold", ifa.O_Instr,        32'h33);
      chk("bp_re_hold",    32'(ifa.O_Re_Buff), 32'd0);
      tick(); ifa.I_Stall = 1'b0; #1;
      chk("bp_re_nocredit", 32'(ifa.O_Re_Buff), 32'd0);
      tick(); #1;
      chk("bp_re_resume", 32'(ifa.O_Re_Buff), 32'd1);

      // Empty window of three cycles
      tick(); tick(); tick(); ifa.I_Empty = 1'b1; #1;
      chk("em_re_0", 32'(ifa.O_Re_Buff), 32'd0);
      tick(); tick(); #1;
      chk("em_re_2", 32'(ifa.O_Re_Buff), 32'd0);
      tick(); ifa.I_Empty = 1'b0; #1;
      chk("em_re_resume", 32'(ifa.O_Re_Buff), 32'd1);
      chk("em_req_gap",   32'(ifa.O_Req),     32'd0);
      tick(); #1;
      chk("em_req_gap2", 32'(ifa.O_Req), 32'd0);
      tick(); #1;
      chk("em_req_back", 32'(ifa.O_Req), 32'd1);

      // Term drain with two queued and one in flight
      tick(); ifa.I_Stall = 1'b1;
      tick(); ifa.I_Stall = 1'b0; ifa.I_Term = 1'b1; pop_mark = npop_a; #1;
      chk("tm_re_term", 32'(ifa.O_Re_Buff), 32'd0);
      tick(); ifa.I_Term = 1'b0; #1;
      chk("tm_re_drain", 32'(ifa.O_Re_Buff), 32'd0);
      chk("tm_busy",     32'(ifa.O_Busy),    32'd1);
      tick(); #1;
      chk("tm_done_early", 32'(ifa.O_Done), 32'd0);
      tick(); #1;
      chk("tm_done",    32'(ifa.O_Done),    32'd1);
      chk("tm_re_done", 32'(ifa.O_Re_Buff), 32'd0);
      tick(); #1;
      chk("tm_busy_idle", 32'(ifa.O_Busy), 32'd0);
      chk("tm_done_once", 32'(ifa.O_Done), 32'd0);
      chk("tm_pops",      32'(npop_a - pop_mark), 32'd3);

      // Flush on RD_LAT=2 instance with three queued and one in flight
      ifb.I_Req = 1'b1;
      tick(); ifb.I_Req = 1'b0; #1;
      chk("fl_re_start", 32'(ifb.O_Re_Buff), 32'd1);
      tick(); tick(); tick(); tick(); #1;
      chk("fl_re_full", 32'(ifb.O_Re_Buff), 32'd0);
      tick(); ifb.I_Flush = 1'b1; exp_b = 4; #1;
      chk("fl_req_pre",   32'(ifb.O_Req),     32'd1);
      chk("fl_instr_pre", ifb.O_Instr,        32'h11);
      chk("fl_re_flush",  32'(ifb.O_Re_Buff), 32'd0);
      tick(); ifb.I_Flush = 1'b0; ifb.I_Req = 1'b1; ifb.I_Stall = 1'b0; #1;
      chk("fl_req_post",  32'(ifb.O_Req),  32'd0);
      chk("fl_busy_post", 32'(ifb.O_Busy), 32'd0);
      tick(); ifb.I_Req = 1'b0; #1;
      chk("fl_busy_rst", 32'(ifb.O_Busy),    32'd1);
      chk("fl_re_rst",   32'(ifb.O_Re_Buff), 32'd1);
      tick(); tick(); #1;
      chk("fl_req_lat", 32'(ifb.O_Req), 32'd0);
      tick(); #1;
      chk("fl_req_first",   32'(ifb.O_Req), 32'd1);
      chk("fl_instr_first", ifb.O_Instr,    32'h55);

      // Reset with instance a full
      ifa.I_Req = 1'b1; ifa.I_Stall = 1'b1;
      tick(); ifa.I_Req = 1'b0;
      repeat (5) tick();
      #1;
      chk("mr_req_full", 32'(ifa.O_Req),     32'd1);
      chk("mr_re_full",  32'(ifa.O_Re_Buff), 32'd0);
      reset = 1'b0;
      tick(); reset = 1'b1; ifa.I_Stall = 1'b0; #1;
      chk("mr_re",    32'(ifa.O_Re_Buff), 32'd0);
      chk("mr_req",   32'(ifa.O_Req),     32'd0);
      chk("mr_instr", ifa.O_Instr,        32'd0);
      chk("mr_busy",  32'(ifa.O_Busy),    32'd0);
      chk("mr_done",  32'(ifa.O_Done),    32'd0);
      chk("mr_b_req", 32'(ifb.O_Req),     32'd0);

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_ifetch_queue

`default_nettype wire
